// File: rtl/retire_monitor_pkg.sv
// Shared RISC-V opcode constants and monitor state type for the retire-stream monitor.
// Imported by the interface users and the monitor top.
package retire_monitor_pkg;

  localparam logic [6:0]  OPC_BRANCH     = 7'b1100011;
  localparam logic [6:0]  OPC_JAL        = 7'b1101111;
  localparam logic [6:0]  OPC_JALR       = 7'b1100111;
  localparam logic [31:0] INST_SELF_LOOP = 32'h0000_006F;

  typedef enum logic [1:0] {
    MON_IDLE,
    MON_RUN,
    MON_HALTED,
    MON_TIMEOUT
  } mon_state_e;

  function automatic logic is_jump(input logic [6:0] opc);
    return (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

endpackage

// File: rtl/retire_monitor_if.sv
// Retire stream bundle: one (pc, instruction) pair per retired op.
// The CPU side drives it; monitors only observe it.
interface retire_monitor_if #(
  parameter int XLEN = 32
) ();

  logic            retire_valid;
  logic [XLEN-1:0] retire_pc;
  logic [31:0]     retire_inst;

  modport master (output retire_valid, retire_pc, retire_inst);
  modport slave  (input  retire_valid, retire_pc, retire_inst);

endinterface

// File: rtl/retire_monitor_sat_counter.sv
// Saturating up-counter with synchronous reset and soft clear.
// Holds at all-ones instead of wrapping; en gates every increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic         en,
  output logic [W-1:0] q
);

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      q <= '0;
    end else if (en && inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/retire_monitor.sv
// End-of-test monitor on the retire stream: counts cycles/instructions/branches/jumps,
// detects the `jal x0, 0` self-loop halt and a RUN-state watchdog timeout.
module retire_monitor
  import retire_monitor_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int CNT_W          = 32,
  parameter int HALT_REPEAT    = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  retire_monitor_if.slave       rt,
  output logic                  done,
  output logic                  halted,
  output logic                  timed_out,
  output logic [XLEN-1:0]       halt_pc,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      instret_cnt,
  output logic [CNT_W-1:0]      branch_cnt,
  output logic [CNT_W-1:0]      jump_cnt
);

  localparam int REP_W = $clog2(HALT_REPEAT + 1);

  mon_state_e       state;
  logic [REP_W-1:0] rep_q;
  logic [REP_W-1:0] rep_nxt;
  logic [XLEN-1:0]  last_loop_pc;

  logic [6:0] opc;
  logic       self_loop;
  logic       active;
  logic       halt_hit;
  logic       timeout_hit;

  assign opc       = rt.retire_inst[6:0];
  assign self_loop = rt.retire_valid && (rt.retire_inst == INST_SELF_LOOP);
  // The entry retire in IDLE is treated exactly like a RUN-cycle retire.
  assign active    = (state == MON_RUN) || ((state == MON_IDLE) && rt.retire_valid);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rep_nxt = rep_q;
    if (rt.retire_valid) begin
      if (self_loop) begin
        if ((rep_q == '0) || (rt.retire_pc == last_loop_pc)) begin
          rep_nxt = rep_q + REP_W'(1);
        end else begin
          rep_nxt = REP_W'(1);
        end
      end else begin
        rep_nxt = '0;
      end
    end
  end

  assign halt_hit    = active && self_loop && (rep_nxt == REP_W'(HALT_REPEAT));
  assign timeout_hit = active && ((64'(cycle_cnt) + 64'd1) == 64'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state        <= MON_IDLE;
      done         <= 1'b0;
      halted       <= 1'b0;
      timed_out    <= 1'b0;
      halt_pc      <= '0;
      rep_q        <= '0;
      last_loop_pc <= '0;
    end else begin
      case (state)
        MON_IDLE, MON_RUN: begin
          if (active) begin
            rep_q <= rep_nxt;
            if (self_loop) begin
              last_loop_pc <= rt.retire_pc;
            end
            // Halt takes priority over a coincident timeout.
            if (halt_hit) begin
              state   <= MON_HALTED;
              halted  <= 1'b1;
              done    <= 1'b1;
              halt_pc <= rt.retire_pc;
            end else if (timeout_hit) begin
              state     <= MON_TIMEOUT;
              timed_out <= 1'b1;
              done      <= 1'b1;
            end else begin
              state <= MON_RUN;
            end
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (1'b1),
    .en    (active),
    .q     (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_instret_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (rt.retire_valid),
    .en    (active),
    .q     (instret_cnt)
  );

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (rt.retire_valid && (opc == OPC_BRANCH)),
    .en    (active),
    .q     (branch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_jump_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (rt.retire_valid && is_jump(opc)),
    .en    (active),
    .q     (jump_cnt)
  );

endmodule
